// File: rtl/mod_div_pkg.sv
// -----------------------------------------------------------------------------
// mod_div_pkg
//   Shared definitions for the iterative divider: the control FSM state type
//   and the special-case result constants (signed minimum, all-ones quotient)
//   as width-parametrised functions so every instance derives its own value.
// -----------------------------------------------------------------------------
package mod_div_pkg;

  localparam int STATE_W   = 2;
  // Upper bound on WIDTH supported by the constant helpers below.
  localparam int MAX_WIDTH = 64;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  // Most negative two's-complement value of the given width (only MSB set).
  function automatic logic [MAX_WIDTH-1:0] signed_min(input int width);
    return {{(MAX_WIDTH-1){1'b0}}, 1'b1} << (width - 1);
  endfunction

  // Quotient returned on division by zero: all ones of the given width.
  function automatic logic [MAX_WIDTH-1:0] all_ones(input int width);
    return ~({MAX_WIDTH{1'b1}} << width);
  endfunction

endpackage

// File: rtl/mod_div_cu.sv
// -----------------------------------------------------------------------------
// mod_div_cu
//   Control unit of the divider: IDLE/CALC/FIX/DONE sequencer plus the
//   iteration counter. Produces one-hot style strobes for the datapath.
// Ports
//   CLK       in  clock, rising edge
//   reset     in  asynchronous reset, active low
//   start     in  operation request, honoured only in IDLE
//   special   in  operands need no iteration (divide by zero / signed overflow)
//   load      out capture operands this cycle
//   shift_en  out perform one shift/subtract step this cycle
//   fix_en    out apply signs and register results this cycle
//   busy      out high in CALC and FIX
//   done      out one-cycle pulse in DONE
// -----------------------------------------------------------------------------
module mod_div_cu
  import mod_div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic CLK,
  input  logic reset,
  input  logic start,
  input  logic special,
  output logic load,
  output logic shift_en,
  output logic fix_en,
  output logic busy,
  output logic done
);

  localparam int CNT_W = $clog2(WIDTH);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;

  // NOTE: every output of a combinational block gets a default at the top so
  // no path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    load     = 1'b0;
    shift_en = 1'b0;
    fix_en   = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          load = 1'b1;
          if (special) begin
            state_d = FIX;
          end else begin
            state_d = CALC;
            cnt_d   = CNT_W'(WIDTH - 1);
          end
        end
      end
      CALC: begin
        busy     = 1'b1;
        shift_en = 1'b1;
        // Counter runs WIDTH-1 down to 0, giving exactly WIDTH steps.
        if (cnt_q == '0) begin
          state_d = FIX;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      FIX: begin
        busy    = 1'b1;
        fix_en  = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        // start is deliberately not looked at here; a new request is only
        // accepted once back in IDLE.
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of block evaluation order.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/mod_div_unit.sv
// -----------------------------------------------------------------------------
// mod_div_unit
//   Radix-2 restoring shift-subtract divider with fixed latency. Works on
//   operand magnitudes and re-applies signs at the end (truncating division:
//   quotient negative iff operand signs differ, remainder follows dividend).
//   Division by zero and signed MIN/-1 bypass the iteration entirely.
// Ports
//   CLK        in  clock, rising edge
//   reset      in  asynchronous reset, active low
//   start      in  request; sampled only when idle
//   is_signed  in  1 = two's-complement operands; sampled with start
//   a, b       in  dividend, divisor; sampled with start
//   busy       out operation in progress
//   done       out one-cycle pulse, results valid
//   quotient   out held from done until the next accepted start
//   remainder  out held from done until the next accepted start
//   div_zero   out last operation divided by zero; held with results
// -----------------------------------------------------------------------------
module mod_div_unit
  import mod_div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  localparam logic [WIDTH-1:0] Q_MIN  = WIDTH'(signed_min(WIDTH));
  localparam logic [WIDTH-1:0] Q_DIV0 = WIDTH'(all_ones(WIDTH));

  logic load, shift_en, fix_en;

  // Iteration state: partial remainder, dividend shifting into quotient,
  // divisor magnitude, and the flags captured at start.
  logic [WIDTH-1:0] rem_q,   rem_d;
  logic [WIDTH-1:0] dvd_q,   dvd_d;
  logic [WIDTH-1:0] dvsr_q,  dvsr_d;
  logic             neg_q_q, neg_q_d;
  logic             neg_r_q, neg_r_d;
  logic             dz_q,    dz_d;
  logic             ovf_q,   ovf_d;

  // Visible results.
  logic [WIDTH-1:0] quotient_q,  quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             div_zero_q,  div_zero_d;

  // Operand decode at start.
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic             b_zero, ovf_in;

  assign a_neg  = is_signed & a[WIDTH-1];
  assign b_neg  = is_signed & b[WIDTH-1];
  assign abs_a  = a_neg ? -a : a;
  assign abs_b  = b_neg ? -b : b;
  assign b_zero = (b == '0);
  assign ovf_in = is_signed && (a == Q_MIN) && (b == '1);

  // One restoring step: shift {rem,dvd} left, trial-subtract the divisor on
  // WIDTH+1 bits; the extra top bit of the difference is the borrow.
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH+1:0] trial;
  logic             borrow;
  logic             unused_trial_bit;

  assign rem_sh           = {rem_q, dvd_q[WIDTH-1]};
  assign trial            = {1'b0, rem_sh} - {2'b00, dvsr_q};
  assign borrow           = trial[WIDTH+1];
  // With no borrow the difference is below the divisor, so bit WIDTH is 0.
  assign unused_trial_bit = trial[WIDTH];

  // Sign fix-up. On divide-by-zero the dividend register still holds |a|,
  // and re-signing it reproduces a exactly (including MIN).
  logic [WIDTH-1:0] r_mag, q_fix, r_fix;

  assign r_mag = dz_q ? dvd_q : rem_q;

  always_comb begin
    q_fix = neg_q_q ? -dvd_q : dvd_q;
    r_fix = neg_r_q ? -r_mag : r_mag;
    if (dz_q) begin
      q_fix = Q_DIV0;
    end else if (ovf_q) begin
      q_fix = Q_MIN;
      r_fix = '0;
    end
  end

  always_comb begin
    rem_d       = rem_q;
    dvd_d       = dvd_q;
    dvsr_d      = dvsr_q;
    neg_q_d     = neg_q_q;
    neg_r_d     = neg_r_q;
    dz_d        = dz_q;
    ovf_d       = ovf_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    div_zero_d  = div_zero_q;

    if (load) begin
      rem_d   = '0;
      dvd_d   = abs_a;
      dvsr_d  = abs_b;
      neg_q_d = a_neg ^ b_neg;
      neg_r_d = a_neg;
      dz_d    = b_zero;
      ovf_d   = ovf_in;
    end

    if (shift_en) begin
      rem_d = borrow ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
      dvd_d = {dvd_q[WIDTH-2:0], ~borrow};
    end

    if (fix_en) begin
      quotient_d  = q_fix;
      remainder_d = r_fix;
      div_zero_d  = dz_q;
    end
  end

  // NOTE: datapath and result registers are all reset (not just the FSM);
  // outputs must read zero during reset and an aborted op leaves no residue.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      rem_q       <= '0;
      dvd_q       <= '0;
      dvsr_q      <= '0;
      neg_q_q     <= 1'b0;
      neg_r_q     <= 1'b0;
      dz_q        <= 1'b0;
      ovf_q       <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      div_zero_q  <= 1'b0;
    end else begin
      rem_q       <= rem_d;
      dvd_q       <= dvd_d;
      dvsr_q      <= dvsr_d;
      neg_q_q     <= neg_q_d;
      neg_r_q     <= neg_r_d;
      dz_q        <= dz_d;
      ovf_q       <= ovf_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      div_zero_q  <= div_zero_d;
    end
  end

  mod_div_cu #(.WIDTH(WIDTH)) u_cu (
    .CLK      (CLK),
    .reset    (reset),
    .start    (start),
    .special  (b_zero | ovf_in),
    .load     (load),
    .shift_en (shift_en),
    .fix_en   (fix_en),
    .busy     (busy),
    .done     (done)
  );

  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign div_zero  = div_zero_q;

endmodule

// File: tb/tb_mod_div_unit.sv
// -----------------------------------------------------------------------------
// tb_mod_div_unit
//   Runs a 32-bit and an 8-bit divider side by side. Directed table vectors,
//   hand-written handshake/reset sequences and random operations checked
//   against a plain-arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_mod_div_unit;

  localparam int WINDOW = 48;  // cycles observed per operation

  logic        CLK;
  logic        reset;

  logic        start_32, is_signed_32, busy_32, done_32, div_zero_32;
  logic [31:0] a_32, b_32, quotient_32, remainder_32;

  logic        start_8, is_signed_8, busy_8, done_8, div_zero_8;
  logic [7:0]  a_8, b_8, quotient_8, remainder_8;

  mod_div_unit #(.WIDTH(32)) dut_32 (
    .CLK(CLK), .reset(reset), .start(start_32), .is_signed(is_signed_32),
    .a(a_32), .b(b_32), .busy(busy_32), .done(done_32),
    .quotient(quotient_32), .remainder(remainder_32), .div_zero(div_zero_32)
  );

  mod_div_unit #(.WIDTH(8)) dut_8 (
    .CLK(CLK), .reset(reset), .start(start_8), .is_signed(is_signed_8),
    .a(a_8), .b(b_8), .busy(busy_8), .done(done_8),
    .quotient(quotient_8), .remainder(remainder_8), .div_zero(div_zero_8)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // What one DUT did during an observation window.
  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    int          lat;       // edges after the start edge until done seen
    int          busy_cnt;
    int          dones;
  } obs_t;

  obs_t o32, o8;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    int          lat;
  } exp_t;

  // Reference: truncating integer division on w-bit operands.
  function automatic exp_t model(input int w, input logic sgn,
                                 input logic [31:0] a, input logic [31:0] b);
    exp_t   e;
    longint mask, minv, ua, ub, sa, sb;
    mask  = (longint'(1) << w) - 1;
    minv  = longint'(1) << (w - 1);
    ua    = longint'({32'b0, a}) & mask;
    ub    = longint'({32'b0, b}) & mask;
    e.dz  = 1'b0;
    e.lat = w + 1;
    if (ub == 0) begin
      e.q   = 32'(mask);
      e.r   = 32'(ua);
      e.dz  = 1'b1;
      e.lat = 1;
    end else if (sgn) begin
      sa = (ua >= minv) ? ua - (mask + 1) : ua;
      sb = (ub >= minv) ? ub - (mask + 1) : ub;
      if (sa == -minv && sb == -1) begin
        e.q   = 32'(minv);
        e.r   = 32'd0;
        e.lat = 1;
      end else begin
        e.q = 32'((sa / sb) & mask);
        e.r = 32'((sa % sb) & mask);
      end
    end else begin
      e.q = 32'(ua / ub);
      e.r = 32'(ua % ub);
    end
    return e;
  endfunction

  task automatic start_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          input logic [7:0] a8, input logic [7:0] b8);
    @(negedge CLK);
    is_signed_32 = sgn;  a_32 = a;  b_32 = b;  start_32 = 1'b1;
    is_signed_8  = sgn;  a_8  = a8; b_8  = b8; start_8  = 1'b1;
  endtask

  // Start an op on both DUTs and observe WINDOW cycles. p32/p8 (>0) pulse a
  // bogus start with new operands at that edge number on the respective DUT.
  task automatic run_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        input logic [7:0] a8, input logic [7:0] b8,
                        input int p32, input int p8);
    o32 = '{q: '0, r: '0, dz: 1'b0, lat: 0, busy_cnt: 0, dones: 0};
    o8  = '{q: '0, r: '0, dz: 1'b0, lat: 0, busy_cnt: 0, dones: 0};
    start_op(sgn, a, b, a8, b8);
    for (int k = 0; k < WINDOW; k++) begin
      @(posedge CLK);
      #1;
      start_32 = 1'b0;
      start_8  = 1'b0;
      if (busy_32) o32.busy_cnt++;
      if (busy_8)  o8.busy_cnt++;
      if (done_32) begin
        o32.dones++;
        if (o32.dones == 1) begin
          o32.lat = k; o32.q = quotient_32; o32.r = remainder_32; o32.dz = div_zero_32;
        end
      end
      if (done_8) begin
        o8.dones++;
        if (o8.dones == 1) begin
          o8.lat = k; o8.q = {24'b0, quotient_8}; o8.r = {24'b0, remainder_8}; o8.dz = div_zero_8;
        end
      end
      if (k + 1 == p32) begin
        start_32 = 1'b1; a_32 = 32'h1; b_32 = 32'h1; is_signed_32 = ~is_signed_32;
      end
      if (k + 1 == p8) begin
        start_8 = 1'b1; a_8 = 8'h1; b_8 = 8'h1; is_signed_8 = ~is_signed_8;
      end
    end
  endtask

  task automatic cmp(input string tag, input obs_t o, input exp_t e);
    check({tag, " quotient"},  o.q, e.q);
    check({tag, " remainder"}, o.r, e.r);
    check({tag, " div_zero"},  {31'b0, o.dz}, {31'b0, e.dz});
    check({tag, " latency"},   32'(o.lat), 32'(e.lat));
    check({tag, " busy_cycles"}, 32'(o.busy_cnt), 32'(e.lat));
    check({tag, " done_count"},  32'(o.dones), 32'd1);
  endtask

  function automatic exp_t mk(input logic [31:0] q, input logic [31:0] r,
                              input logic dz, input int lat);
    exp_t e;
    e.q = q; e.r = r; e.dz = dz; e.lat = lat;
    return e;
  endfunction

  typedef struct {
    logic        sgn;
    logic [31:0] a, b, q, r;
    logic        dz;
    int          lat;
    logic [7:0]  a8, b8, q8, r8;
    logic        dz8;
    int          lat8;
  } vec_t;

  vec_t tbl[10];

  initial begin
    tbl[0] = '{1'b0, 32'd100,       32'd7,         32'd14,        32'd2,         1'b0, 33,
               8'd255, 8'd16, 8'd15, 8'd15, 1'b0, 9};
    tbl[1] = '{1'b1, 32'hFFFFFF9C,  32'd7,         32'hFFFFFFF2,  32'hFFFFFFFE,  1'b0, 33,
               8'h9C, 8'h07, 8'hF2, 8'hFE, 1'b0, 9};
    tbl[2] = '{1'b1, 32'd100,       32'hFFFFFFF9,  32'hFFFFFFF2,  32'd2,         1'b0, 33,
               8'h64, 8'hF9, 8'hF2, 8'h02, 1'b0, 9};
    tbl[3] = '{1'b0, 32'h1234,      32'd0,         32'hFFFFFFFF,  32'h1234,      1'b1, 1,
               8'h34, 8'h00, 8'hFF, 8'h34, 1'b1, 1};
    tbl[4] = '{1'b1, 32'h80000000,  32'hFFFFFFFF,  32'h80000000,  32'd0,         1'b0, 1,
               8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, 1};
    tbl[5] = '{1'b0, 32'd5,         32'd9,         32'd0,         32'd5,         1'b0, 33,
               8'd3, 8'd200, 8'd0, 8'd3, 1'b0, 9};
    tbl[6] = '{1'b1, 32'hFFFFFFF9,  32'hFFFFFFFE,  32'd3,         32'hFFFFFFFF,  1'b0, 33,
               8'hF9, 8'hFE, 8'h03, 8'hFF, 1'b0, 9};
    tbl[7] = '{1'b1, 32'hFFFFFFFB,  32'd0,         32'hFFFFFFFF,  32'hFFFFFFFB,  1'b1, 1,
               8'hFB, 8'h00, 8'hFF, 8'hFB, 1'b1, 1};
    tbl[8] = '{1'b0, 32'hFFFFFFFF,  32'd1,         32'hFFFFFFFF,  32'd0,         1'b0, 33,
               8'hFF, 8'h01, 8'hFF, 8'h00, 1'b0, 9};
    tbl[9] = '{1'b0, 32'h80000000,  32'hFFFFFFFF,  32'd0,         32'h80000000,  1'b0, 33,
               8'h80, 8'hFF, 8'h00, 8'h80, 1'b0, 9};

    reset    = 1'b0;
    start_32 = 1'b0; is_signed_32 = 1'b0; a_32 = '0; b_32 = '0;
    start_8  = 1'b0; is_signed_8  = 1'b0; a_8  = '0; b_8  = '0;

    // Reset state.
    repeat (2) @(posedge CLK);
    #1;
    check("reset busy", {30'b0, busy_32, busy_8}, 32'd0);
    check("reset done", {30'b0, done_32, done_8}, 32'd0);
    check("reset quotient32", quotient_32, 32'd0);
    check("reset remainder32", remainder_32, 32'd0);
    check("reset flags/8bit", {8'b0, quotient_8, remainder_8, 6'b0, div_zero_32, div_zero_8}, 32'd0);
    @(negedge CLK);
    reset = 1'b1;

    // Directed vectors.
    for (int i = 0; i < 10; i++) begin
      run_op(tbl[i].sgn, tbl[i].a, tbl[i].b, tbl[i].a8, tbl[i].b8, -1, -1);
      cmp($sformatf("tbl%0d w32", i), o32, mk(tbl[i].q, tbl[i].r, tbl[i].dz, tbl[i].lat));
      cmp($sformatf("tbl%0d w8", i),  o8,
          mk({24'b0, tbl[i].q8}, {24'b0, tbl[i].r8}, tbl[i].dz8, tbl[i].lat8));
    end

    // start pulsed mid-CALC with new operands: ignored.
    run_op(1'b0, 32'd100, 32'd7, 8'd255, 8'd16, 5, 5);
    cmp("start_in_calc w32", o32, mk(32'd14, 32'd2, 1'b0, 33));
    cmp("start_in_calc w8",  o8,  mk(32'd15, 32'd15, 1'b0, 9));

    // start asserted while in DONE: ignored, no second operation.
    run_op(1'b0, 32'd100, 32'd7, 8'd255, 8'd16, 34, 10);
    cmp("start_in_done w32", o32, mk(32'd14, 32'd2, 1'b0, 33));
    cmp("start_in_done w8",  o8,  mk(32'd15, 32'd15, 1'b0, 9));
    check("hold quotient32",  quotient_32,  32'd14);
    check("hold remainder8",  {24'b0, remainder_8}, 32'd15);

    // Reset in the middle of an operation.
    start_op(1'b0, 32'd100, 32'd7, 8'd255, 8'd16);
    @(posedge CLK);
    #1;
    start_32 = 1'b0;
    start_8  = 1'b0;
    repeat (9) @(posedge CLK);
    #2 reset = 1'b0;
    #1;
    check("midop_reset q32", quotient_32, 32'd0);
    check("midop_reset r32", remainder_32, 32'd0);
    check("midop_reset ctl", {26'b0, busy_32, done_32, div_zero_32, busy_8, done_8, div_zero_8}, 32'd0);
    check("midop_reset w8", {16'b0, quotient_8, remainder_8}, 32'd0);
    repeat (2) @(negedge CLK);
    reset = 1'b1;
    begin
      int activity = 0;
      for (int k = 0; k < 40; k++) begin
        @(posedge CLK);
        #1;
        if (busy_32 || done_32 || busy_8 || done_8) activity++;
      end
      check("after_reset idle", 32'(activity), 32'd0);
    end
    run_op(1'b0, 32'd9, 32'd4, 8'd9, 8'd4, -1, -1);
    cmp("post_reset w32", o32, mk(32'd2, 32'd1, 1'b0, 33));
    cmp("post_reset w8",  o8,  mk(32'd2, 32'd1, 1'b0, 9));

    // Random operations against the reference model.
    for (int i = 0; i < 150; i++) begin
      logic        sgn;
      logic [31:0] ra, rb;
      logic [7:0]  ra8, rb8;
      int          sel;
      sgn = 1'(($urandom() & 32'h1));
      ra  = $urandom();
      rb  = $urandom();
      ra8 = 8'($urandom());
      rb8 = 8'($urandom());
      sel = int'($urandom_range(0, 7));
      case (sel)
        0: begin rb = '0; rb8 = '0; end
        1: begin ra = 32'h80000000; rb = '1; ra8 = 8'h80; rb8 = 8'hFF; end
        2: begin rb = $urandom_range(1, 15); rb8 = 8'($urandom_range(1, 15)); end
        3: begin rb = ra + $urandom_range(1, 9); rb8 = ra8 + 8'($urandom_range(1, 9)); end
        default: ;
      endcase
      run_op(sgn, ra, rb, ra8, rb8, -1, -1);
      cmp($sformatf("rnd%0d w32", i), o32, model(32, sgn, ra, rb));
      cmp($sformatf("rnd%0d w8", i),  o8,  model(8, sgn, {24'b0, ra8}, {24'b0, rb8}));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
